// File: rtl/expr_eval_sched.sv
// Round-robin scheduler that time-shares one expression datapath among NREQ requesters.
// Optional response parity is enabled by defining EXPR_SCHED_PARITY_EN.
module expr_eval_sched #(
  parameter int NREQ = 2,
  parameter int LAT  = 1,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*30-1:0] req_a,
  input  logic [NREQ*30-1:0] req_b,
  output logic [29:0]       dp_a,
  output logic [29:0]       dp_b,
  output logic              dp_valid,
  input  logic [89:0]       dp_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [89:0]       rsp_y,
  output logic              rsp_par
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t         state_q;
  logic [IDW-1:0] last_q;
  logic [IDW-1:0] curId_q;
  logic [3:0]     cnt_q;
  logic [29:0]    dpA_q;
  logic [29:0]    dpB_q;
  logic           dpValid_q;
  logic           rspValid_q;
  logic [IDW-1:0] rspId_q;
  logic [89:0]    rspY_q;

  logic [IDW-1:0] grantIdx;
  logic           grantHit;
  logic           accept;

  // First valid requester strictly after the last one served, wrapping around.
  always_comb begin
    int idx;
    idx      = 0;
    grantIdx = '0;
    grantHit = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grantHit && req_valid[idx]) begin
        grantHit = 1'b1;
        grantIdx = IDW'(idx);
      end
    end
  end

  assign req_ready = (state_q == IDLE && grantHit)
                   ? ({{(NREQ-1){1'b0}}, 1'b1} << grantIdx) : '0;
  assign accept    = |(req_valid & req_ready);

`ifdef EXPR_SCHED_PARITY_EN
  logic rspPar_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= IDW'(NREQ - 1);
      curId_q    <= '0;
      cnt_q      <= '0;
      dpA_q      <= '0;
      dpB_q      <= '0;
      dpValid_q  <= 1'b0;
      rspValid_q <= 1'b0;
      rspId_q    <= '0;
      rspY_q     <= '0;
`ifdef EXPR_SCHED_PARITY_EN
      rspPar_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            dpA_q     <= req_a[30*grantIdx +: 30];
            dpB_q     <= req_b[30*grantIdx +: 30];
            curId_q   <= grantIdx;
            last_q    <= grantIdx;
            cnt_q     <= 4'(LAT - 1);
            dpValid_q <= 1'b1;
            state_q   <= DRIVE;
          end
        end
        DRIVE: begin
          // Operands stay put for LAT cycles so the datapath output has settled.
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rspY_q     <= dp_y;
            rspId_q    <= curId_q;
            rspValid_q <= 1'b1;
            dpValid_q  <= 1'b0;
            state_q    <= RESP;
`ifdef EXPR_SCHED_PARITY_EN
            rspPar_q   <= ^dp_y;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            state_q    <= IDLE;
`ifdef EXPR_SCHED_PARITY_EN
            rspPar_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dp_a      = dpA_q;
  assign dp_b      = dpB_q;
  assign dp_valid  = dpValid_q;
  assign rsp_valid = rspValid_q;
  assign rsp_id    = rspId_q;
  assign rsp_y     = rspY_q;

`ifdef EXPR_SCHED_PARITY_EN
  assign rsp_par = rspPar_q;
`else
  assign rsp_par = 1'b0;
`endif

endmodule

// File: tb/tb_expr_eval_sched.sv
// Self-checking bench for expr_eval_sched: transaction-level model of grant order,
// operand hand-off, capture timing, backpressure and reset abandonment.
module tb_expr_eval_sched;

  localparam int NREQ = 3;
  localparam int LAT  = 3;
  localparam int IDW  = $clog2(NREQ);

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*30-1:0] req_a;
  logic [NREQ*30-1:0] req_b;
  logic [29:0]        dp_a;
  logic [29:0]        dp_b;
  logic               dp_valid;
  logic [89:0]        dp_y;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [89:0]        rsp_y;
  logic               rsp_par;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  int mLast  = NREQ - 1;
  int lastAccept = 0;
  logic [29:0] expDpA;
  logic [29:0] expDpB;
  logic [89:0] yHist [int];
  bit          yForceEn = 1'b0;
  logic [89:0] yForce   = '0;

  expr_eval_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_valid  (dp_valid),
    .dp_y      (dp_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_par   (rsp_par)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: a fresh value every cycle, remembered per cycle number.
  initial begin
    dp_y = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      dp_y = yForceEn ? yForce : 90'({$urandom, $urandom, $urandom});
      yHist[cyc] = dp_y;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [89:0] obs, input logic [89:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int expGrant(input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(mLast + k) % NREQ]) return (mLast + k) % NREQ;
    end
    return 0;
  endfunction

  function automatic logic expParity(input logic [89:0] y);
`ifdef EXPR_SCHED_PARITY_EN
    return ^y;
`else
    return 1'b0;
`endif
  endfunction

  // One full request/response transaction; rspDelay cycles of backpressure.
  task automatic applyStimulus(input logic [NREQ-1:0] mask, input int rspDelay, input bit checkSpacing);
    int g;
    int p;
    logic [89:0] ey;
    req_valid = mask;
    req_a     = 90'({$urandom, $urandom, $urandom});
    req_b     = 90'({$urandom, $urandom, $urandom});
    rsp_ready = (rspDelay == 0);
    #1;
    g = expGrant(mask);
    checkOutput("grant_ready", req_ready, NREQ'(1) << g);
    expDpA = req_a[30*g +: 30];
    expDpB = req_b[30*g +: 30];
    tick;
    p = cyc;
    mLast = g;
    if (checkSpacing) checkOutput("accept_spacing", p - lastAccept, LAT + 2);
    lastAccept = p;
    checkOutput("dp_a", dp_a, expDpA);
    checkOutput("dp_b", dp_b, expDpB);
    checkOutput("dp_valid_rise", dp_valid, 1);
    checkOutput("drive_req_ready", req_ready, 0);
    req_a = 90'({$urandom, $urandom, $urandom});
    req_b = 90'({$urandom, $urandom, $urandom});
    for (int i = 1; i < LAT; i++) begin
      tick;
      checkOutput("dp_valid_hold", dp_valid, 1);
      checkOutput("dp_a_hold", dp_a, expDpA);
      checkOutput("rsp_valid_early", rsp_valid, 0);
    end
    tick;
    ey = yHist[p + LAT - 1];
    checkOutput("dp_valid_drop", dp_valid, 0);
    checkOutput("rsp_valid_rise", rsp_valid, 1);
    checkOutput("rsp_id", rsp_id, g);
    checkOutput("rsp_y", rsp_y, ey);
    checkOutput("rsp_par", rsp_par, expParity(ey));
    for (int i = 0; i < rspDelay; i++) begin
      checkOutput("bp_req_ready", req_ready, 0);
      tick;
      checkOutput("bp_rsp_valid", rsp_valid, 1);
      checkOutput("bp_rsp_y", rsp_y, ey);
      checkOutput("bp_rsp_id", rsp_id, g);
    end
    rsp_ready = 1'b1;
    tick;
    checkOutput("rsp_valid_clear", rsp_valid, 0);
  endtask

  initial begin
    int g;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick;
    tick;
    checkOutput("reset_dp_a", dp_a, 0);
    checkOutput("reset_dp_b", dp_b, 0);
    checkOutput("reset_dp_valid", dp_valid, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_id", rsp_id, 0);
    checkOutput("reset_rsp_y", rsp_y, 0);
    checkOutput("reset_rsp_par", rsp_par, 0);
    req_valid = '1;
    #1;
    checkOutput("reset_grant_req0", req_ready, 1);
    req_valid = '0;
    rst_n = 1'b1;
    tick;
    checkOutput("idle_no_ready", req_ready, 0);

    $display("[TB] single request");
    applyStimulus(3'b001, 0, 1'b0);

    req_valid = '0;
    tick;
    checkOutput("idle_dp_a_hold", dp_a, expDpA);
    checkOutput("idle_dp_valid", dp_valid, 0);

    $display("[TB] round robin, all valid");
    for (int i = 0; i < 4; i++) applyStimulus('1, 0, i > 0);

    $display("[TB] backpressure");
    applyStimulus(3'b101, 5, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 10; i++)
      applyStimulus(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(0, 3), 1'b0);

    $display("[TB] parity values");
    yForceEn = 1'b1;
    yForce   = 90'h7;
    applyStimulus('1, 0, 1'b0);
    yForce   = 90'h3;
    applyStimulus('1, 0, 1'b0);
    yForceEn = 1'b0;

    $display("[TB] reset mid-drive");
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    g = expGrant(req_valid);
    checkOutput("rst_case_grant", req_ready, NREQ'(1) << g);
    tick;
    checkOutput("rst_case_dp_valid", dp_valid, 1);
    rst_n = 1'b0;
    tick;
    checkOutput("rst_mid_dp_valid", dp_valid, 0);
    checkOutput("rst_mid_rsp_valid", rsp_valid, 0);
    checkOutput("rst_mid_dp_a", dp_a, 0);
    checkOutput("rst_mid_dp_b", dp_b, 0);
    mLast = NREQ - 1;
    rst_n = 1'b1;
    req_valid = '0;
    for (int i = 0; i < LAT + 3; i++) begin
      tick;
      checkOutput("rst_no_response", rsp_valid, 0);
    end
    applyStimulus('1, 0, 1'b0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/expr_eval_sched.md
# expr_eval_sched

Round-robin scheduler that shares one combinational expression-evaluation datapath among `NREQ` requesters. Each granted request has its packed `a`/`b` operand set registered onto the datapath inputs. The block holds those operands stable for `LAT` cycles, then captures the 90-bit result and returns it on a shared response channel tagged with the requester id. It sits between request sources and the `a0..a5`/`b0..b5` → `y` evaluation block, and is the only driver of that block's inputs.

## Interface
- `NREQ`, 2 — number of requesters, legal range 2..8; `IDW = $clog2(NREQ)`.
- `LAT`, 1 — datapath settle cycles, legal range 1..15.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept.
- `req_a`  in  NREQ*30  per-requester operands, packed `{a0[3:0],a1[4:0],a2[5:0],a3[3:0],a4[4:0],a5[5:0]}`, MSB first; requester i occupies slice `[30*i+:30]`.
- `req_b`  in  NREQ*30  same packing for `b0..b5`.
- `dp_a`  out  30  registered operands to the datapath.
- `dp_b`  out  30  registered operands to the datapath.
- `dp_valid`  out  1  high while `dp_a`/`dp_b` hold a live operand set.
- `dp_y`  in  90  datapath result.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  IDW  requester index of the response.
- `rsp_y`  out  90  captured result.
- `rsp_par`  out  1  even parity of `rsp_y`; present only with the `EXPR_SCHED_PARITY_EN` feature (see Configuration).

## Operation
- The FSM has three states: IDLE, DRIVE, RESP.
- **IDLE**
  - Combinational round-robin grant over `req_valid`, searching from `last+1` upward with wrap.
  - `req_ready[g]` is high only for the granted index `g`; all other `req_ready` bits are low.
  - On `req_valid[g] && req_ready[g]`:
    - latch `req_a`/`req_b` slice `g` into `dp_a`/`dp_b`;
    - set `cur_id=g` and `last=g`;
    - load `cnt=LAT-1`, set `dp_valid=1`, go to DRIVE.
  - No valid request: stay in IDLE; `dp_a`/`dp_b` keep their last values.
- **DRIVE**
  - `req_ready` is all-zero.
  - While `cnt!=0`: decrement `cnt`.
  - When `cnt==0`: capture `rsp_y<=dp_y` and `rsp_id<=cur_id`, set `rsp_valid=1` and `dp_valid=0`, go to RESP.
- **RESP**
  - `rsp_valid`, `rsp_id` and `rsp_y` are held stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`: clear `rsp_valid`, go to IDLE.
  - `req_ready` is all-zero throughout RESP.
- Requests are never reordered, and there is at most one in flight.
- A requester that drops `req_valid` before it is granted loses nothing; no state is kept for it.
- `last` updates only on accept. Fairness: a continuously valid requester waits at most `NREQ-1` services.

## Timing
- **Reset values:** state IDLE, `last=NREQ-1` (so requester 0 wins first), `req_ready` per grant rule, `dp_a=0`, `dp_b=0`, `dp_valid=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_y=0`, `rsp_par=0`, `cnt=0`.
- **Accept-to-response:**
  - accept edge at cycle T;
  - `dp_a`/`dp_b` valid from T+1;
  - capture at the end of cycle T+LAT;
  - `rsp_valid` high from cycle T+LAT+1.
- **Throughput:** with `rsp_ready` tied high, the next accept is at T+LAT+2, giving one result per LAT+2 cycles.
- **Reset mid-operation:** `rst_n=0` in DRIVE or RESP abandons the transaction; no response is issued, and all registers return to their reset values on that edge.
- **Simultaneous requests:** exactly one is granted per IDLE cycle.
- `req_ready` depends on `req_valid` combinationally.
- No other combinational input-to-output paths exist.

## Configuration
- `EXPR_SCHED_PARITY_EN` defined:
  - `rsp_par` is registered with `rsp_y` as `^dp_y` at capture;
  - it is valid exactly while `rsp_valid` is high.
- `EXPR_SCHED_PARITY_EN` undefined: the `rsp_par` port is still present but tied to 0, and no parity logic is built.

## Test plan
- **Single request, `LAT=1`:** `req_valid=01`, `req_a=30'h1`, datapath model returns `y=90'h5`.
  - `dp_a=30'h1` at T+1, `dp_valid=1` for exactly one cycle.
  - `rsp_valid` at T+2 with `rsp_id=0`, `rsp_y=90'h5`.
- **Round-robin order:** `NREQ=2`, `req_valid=11` held constantly, `rsp_ready=1`.
  - Grant order is 0,1,0,1.
  - Accepts are spaced 3 cycles apart.
- **Backpressure:** `rsp_ready=0` for 5 cycles after `rsp_valid` rises.
  - `rsp_y`/`rsp_id` are stable and `req_ready=00` throughout.
  - Once `rsp_ready=1`: IDLE next cycle, and a new grant follows.
- **Latency sweep:** `LAT=3`.
  - `dp_valid` is high for 3 cycles.
  - `rsp_valid` at T+4.
  - `rsp_y` equals the value of `dp_y` at T+3, not a later value.
- **Reset mid-DRIVE:** assert `rst_n=0` at T+1 with `LAT=3`.
  - Next cycle: `dp_valid=0`, `rsp_valid=0`, `dp_a=0`.
  - No response ever appears for that request.
  - The first grant after reset goes to requester 0.
- **Parity:** with `EXPR_SCHED_PARITY_EN`, `dp_y=90'h7` gives `rsp_par=1` and `dp_y=90'h3` gives `rsp_par=0`; without the macro, `rsp_par` is always 0.
